// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared constants, FSM states and word helpers for the inverse AES-128 key schedule
// Contents: NR/CNT_W defaults, word-slice indices of a 128-bit round key,
// state_e enum, rcon() round-constant lookup, rot_word() byte rotation.
package aes_key_pkg;

    localparam int NR    = 10;
    localparam int CNT_W = 4;

    // MSB index of each 32-bit word inside a 128-bit key (w0 is the leftmost word)
    localparam int W0_HI = 127;
    localparam int W1_HI = 95;
    localparam int W2_HI = 63;
    localparam int W3_HI = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_PREP,
        ST_SUB,
        ST_MIX
    } state_e;

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box (GF(2^8) inverse followed by the affine map)
// Ports: in_byte [7:0] input byte, out_byte [7:0] substituted byte.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    // Built as x^2 * x^4 * ... * x^128 so only 7 squarings and 7 products are needed.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] acc;
        s   = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s   = gf_mul(s, s);
            acc = gf_mul(acc, s);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - iterative inverse AES-128 key expander streaming round keys NR..0
// Ports: clk, rst_n (async active-low); start + last_key[127:0] request a run from IDLE;
// round_key[127:0]/round_num[CNT_W-1:0] qualified by key_valid, accepted with key_ready;
// busy spans the run; done pulses the cycle after the round-0 key is accepted.
module aes_inv_key_schedule
    import aes_key_pkg::*;
#(
    parameter int NR    = aes_key_pkg::NR,
    parameter int CNT_W = aes_key_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [127:0]     last_key,
    output logic             busy,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [127:0]     round_key,
    output logic [CNT_W-1:0] round_num,
    output logic             done
);

    state_e             state_q, state_d;
    logic [127:0]       round_key_q, round_key_d;
    logic [CNT_W-1:0]   round_num_q, round_num_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        temp_q, temp_d;
    logic [31:0]        w0_save_q, w0_save_d;
    logic               done_q, done_d;

    logic [31:0]        w0, w1, w2, w3;
    logic [7:0]         sbox_in, sbox_out;
    logic [31:0]        temp_sub;

    assign w0 = round_key_q[W0_HI -: 32];
    assign w1 = round_key_q[W1_HI -: 32];
    assign w2 = round_key_q[W2_HI -: 32];
    assign w3 = round_key_q[W3_HI -: 32];

    // One S-box shared over four cycles; idx_q picks the byte of t, MSB first.
    always_comb begin
        case (idx_q)
            2'd0:    sbox_in = temp_q[31:24];
            2'd1:    sbox_in = temp_q[23:16];
            2'd2:    sbox_in = temp_q[15:8];
            default: sbox_in = temp_q[7:0];
        endcase
    end

    aes_sbox u_sbox (
        .in_byte  (sbox_in),
        .out_byte (sbox_out)
    );

    always_comb begin
        temp_sub = temp_q;
        case (idx_q)
            2'd0:    temp_sub[31:24] = sbox_out;
            2'd1:    temp_sub[23:16] = sbox_out;
            2'd2:    temp_sub[15:8]  = sbox_out;
            default: temp_sub[7:0]   = sbox_out;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_num_d = round_num_q;
        idx_d       = idx_q;
        temp_d      = temp_q;
        w0_save_d   = w0_save_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    round_key_d = last_key;
                    round_num_d = CNT_W'(NR);
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (key_ready) begin
                    if (round_num_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PREP;
                    end
                end
            end
            ST_PREP: begin
                // Words 1..3 of the previous key fall out of XORs of adjacent words;
                // word 0 needs SubWord(RotWord(n3)), so keep w0 aside until MIX.
                round_key_d[W1_HI -: 32] = w1 ^ w0;
                round_key_d[W2_HI -: 32] = w2 ^ w1;
                round_key_d[W3_HI -: 32] = w3 ^ w2;
                w0_save_d                = w0;
                temp_d                   = rot_word(w3 ^ w2);
                idx_d                    = 2'd0;
                state_d                  = ST_SUB;
            end
            ST_SUB: begin
                temp_d = temp_sub;
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = ST_MIX;
            end
            ST_MIX: begin
                round_key_d[W0_HI -: 32] = w0_save_q ^ temp_q ^ {rcon(round_num_q), 24'h0};
                round_num_d              = round_num_q - CNT_W'(1);
                state_d                  = ST_EMIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            round_key_q <= '0;
            round_num_q <= '0;
            idx_q       <= '0;
            temp_q      <= '0;
            w0_save_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_num_q <= round_num_d;
            idx_q       <= idx_d;
            temp_q      <= temp_d;
            w0_save_q   <= w0_save_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign key_valid = (state_q == ST_EMIT);
    assign round_key = round_key_q;
    assign round_num = round_num_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - self-checking bench for aes_inv_key_schedule against a forward-expansion model
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] last_key;
    logic         busy;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_inv_key_schedule #(.NR(10), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .last_key  (last_key),
        .busy      (busy),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_num (round_num),
        .done      (done)
    );

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct {
        logic [127:0] rk10;
        logic [127:0] rk1;
        logic [127:0] rk0;
    } vec_t;

    vec_t         vecs [2];
    logic [127:0] exp_rk [11];
    logic [127:0] got_key [11];
    int           got_num [11];
    int           got_cnt;
    int           done_cycles;

    function automatic logic [7:0] ref_sbox(input logic [7:0] b);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8*int'(b) -: 8];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Forward FIPS-197 key expansion; exp_rk[r] is the round-r key.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Runs one stream from the current sample point; returns in the cycle done is seen.
    task automatic run_stream(input logic [127:0] lk, input int stall_round, input int stall_len,
                              input bit inject);
        int           cyc;
        int           stalls;
        int           since_hs;
        bit           holding;
        bit           seen_done;
        logic [127:0] held_key;
        logic [3:0]   held_num;
        got_cnt     = 0;
        stalls      = 0;
        since_hs    = 0;
        holding     = 1'b0;
        seen_done   = 1'b0;
        done_cycles = -1;
        held_key    = '0;
        held_num    = '0;
        for (int i = 0; i < 11; i++) begin
            got_key[i] = '0;
            got_num[i] = -1;
        end
        last_key  = lk;
        start     = 1'b1;
        key_ready = 1'b0;
        @(posedge clk); #1;
        start    = 1'b0;
        last_key = ~lk;
        cyc      = 1;
        check("first_valid", 128'(key_valid), 128'd1);
        check("done_clear", 128'(done), 128'd0);
        while (cyc < 300 && !seen_done) begin
            if (done) begin
                seen_done   = 1'b1;
                done_cycles = cyc;
                check("busy_at_done", 128'(busy), 128'd0);
            end else begin
                if (holding) begin
                    check("hold_valid", 128'(key_valid), 128'd1);
                    check("hold_key", round_key, held_key);
                    check("hold_num", 128'(round_num), 128'(held_num));
                    holding = 1'b0;
                end
                if (key_valid) begin
                    since_hs = 0;
                    if (int'(round_num) == stall_round && stalls < stall_len) begin
                        key_ready = 1'b0;
                        holding   = 1'b1;
                        held_key  = round_key;
                        held_num  = round_num;
                        stalls++;
                    end else begin
                        key_ready = 1'b1;
                        if (got_cnt < 11) begin
                            got_key[got_cnt] = round_key;
                            got_num[got_cnt] = int'(round_num);
                        end
                        got_cnt++;
                    end
                end else begin
                    key_ready = 1'($urandom_range(0, 1));
                    since_hs++;
                end
                start = inject && !key_valid && since_hs == 2 && round_num == 4'd9;
                if (start) last_key = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
                cyc++;
            end
        end
        start     = 1'b0;
        key_ready = 1'b0;
        check("key_count", 128'(got_cnt), 128'd11);
        check("done_cycles", 128'(done_cycles), 128'(72 + stall_len));
        for (int i = 0; i < 11; i++) begin
            check($sformatf("rk%0d", 10 - i), got_key[i], exp_rk[10 - i]);
            check($sformatf("num%0d", 10 - i), 128'(got_num[i]), 128'(10 - i));
        end
    endtask

    initial begin
        int guard;
        vecs[0] = '{rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    rk1:  128'ha0fafe1788542cb123a339392a6c7605,
                    rk0:  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                    rk1:  128'h62636363626363636263636362636363,
                    rk0:  128'h0};

        rst_n     = 1'b0;
        start     = 1'b0;
        key_ready = 1'b0;
        last_key  = '0;
        @(posedge clk); #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(key_valid), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_key", round_key, 128'd0);
        check("rst_num", 128'(round_num), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known vectors, second one started in the cycle after the first done
        for (int v = 0; v < 2; v++) begin
            expand(vecs[v].rk0);
            run_stream(vecs[v].rk10, -1, 0, 1'b0);
            check($sformatf("vec%0d_rk10", v), got_key[0], vecs[v].rk10);
            check($sformatf("vec%0d_rk1", v), got_key[9], vecs[v].rk1);
            check($sformatf("vec%0d_rk0", v), got_key[10], vecs[v].rk0);
        end
        expand(vecs[0].rk0);
        check("fips_rk9", exp_rk[9], 128'hac7766f319fadc2128d12941575c006e);

        @(posedge clk); #1;
        check("done_pulse_end", 128'(done), 128'd0);

        // Backpressure on round 7 for 5 cycles
        run_stream(vecs[0].rk10, 7, 5, 1'b0);
        @(posedge clk); #1;

        // start pulsed with a different key during SUB
        run_stream(vecs[0].rk10, -1, 0, 1'b1);
        @(posedge clk); #1;

        // Reset during SUB of round 4
        last_key  = vecs[0].rk10;
        start     = 1'b1;
        key_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!(key_valid && round_num == 4'd5) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reach_round5", 128'(guard < 100), 128'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sub_busy", 128'(busy && !key_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 128'(key_valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_key", round_key, 128'd0);
        check("midrst_num", 128'(round_num), 128'd0);
        // start across an edge while reset is still asserted is not accepted
        start    = 1'b1;
        last_key = vecs[1].rk10;
        @(posedge clk); #1;
        check("rst_start_ignored", 128'(busy), 128'd0);
        start     = 1'b0;
        key_ready = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        run_stream(vecs[0].rk10, -1, 0, 1'b0);
        @(posedge clk); #1;

        // Random keys with random short stalls
        for (int k = 0; k < 6; k++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            run_stream(exp_rk[10], int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), 1'b0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
